// File: rtl/root_pkg.sv
// Shared definitions for the root-engine request front-end.
// FSM encodings, datapath widths and small helpers used by root_dispatch.
package root_pkg;

    // Datapath widths of the root engine interface.
    localparam int unsigned RADICAND_W = 10;
    localparam int unsigned DEGREE_W   = 3;
    localparam int unsigned RESULT_W   = 20;
    localparam int unsigned FRAC_W     = 10;

    // Legacy state encodings, kept so existing waveform decoders still match.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_REJECT = 3'd3;
    localparam logic [2:0] S_BYPASS = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = S_IDLE,
        ISSUE  = S_ISSUE,
        WAIT   = S_WAIT,
        REJECT = S_REJECT,
        BYPASS = S_BYPASS,
        RESP   = S_RESP
    } root_state_e;

    // Requests whose root is trivial: degree 1 (identity) or radicand 0.
    // Degree 0 is never eligible; it is rejected instead.
    function automatic logic bypass_eligible(
        input logic [RADICAND_W-1:0] rad,
        input logic [DEGREE_W-1:0]   deg
    );
        return (deg != '0) && ((deg == DEGREE_W'(1)) || (rad == '0));
    endfunction

    // Q10.10 result of a trivial root: the integer itself for degree 1,
    // zero otherwise (radicand 0).
    function automatic logic [RESULT_W-1:0] bypass_result(
        input logic [RADICAND_W-1:0] rad,
        input logic [DEGREE_W-1:0]   deg
    );
        if (deg == DEGREE_W'(1)) begin
            return {rad, {FRAC_W{1'b0}}};
        end
        return '0;
    endfunction

endpackage

// File: rtl/root_req_fifo.sv
// Synchronous request FIFO for root_dispatch.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// Count, full and empty are all registered; no fall-through, so an entry
// pushed in cycle t is visible at rdata_o from cycle t+1.
module root_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push;
    logic             do_pop;

    // Requests beyond capacity or pops of an empty FIFO are dropped here,
    // so the count can never wrap.
    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    // Next pointer, count and flag values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Pointer, count and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/root_dispatch.sv
// Request front-end for the fixed-point root engine.
// Buffers (radicand, degree, tag) requests, issues them to the engine one at
// a time with operands held stable, and returns each result on a ready/valid
// response port. Degree-0 requests are rejected without touching the engine.
// Optional feature: define ROOT_DISPATCH_BYPASS_EN to answer degree-1 and
// radicand-0 requests locally instead of through the engine.
module root_dispatch
    import root_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    // request port
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [RADICAND_W-1:0] req_radicand,
    input  logic [DEGREE_W-1:0]   req_degree,
    input  logic [TAG_W-1:0]      req_tag,
    // engine port
    output logic                  eng_in_valid,
    output logic [RADICAND_W-1:0] eng_data_1,
    output logic [DEGREE_W-1:0]   eng_data_2,
    input  logic                  eng_out_valid,
    input  logic [RESULT_W-1:0]   eng_out_data,
    // response port
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [RESULT_W-1:0]   rsp_data,
    output logic [TAG_W-1:0]      rsp_tag,
    output logic                  rsp_err
);

    localparam int unsigned ENTRY_W = RADICAND_W + DEGREE_W + TAG_W;

    logic [ENTRY_W-1:0]    fifo_wdata;
    logic [ENTRY_W-1:0]    fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;

    logic [RADICAND_W-1:0] pop_rad;
    logic [DEGREE_W-1:0]   pop_deg;
    logic [TAG_W-1:0]      pop_tag;

    root_state_e           state_q, state_d;
    logic [RADICAND_W-1:0] rad_q;
    logic [DEGREE_W-1:0]   deg_q;
    logic [TAG_W-1:0]      tag_q;
    logic [RESULT_W-1:0]   rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;

    assign fifo_wdata = {req_radicand, req_degree, req_tag};
    assign fifo_push  = req_valid && req_ready;
    assign req_ready  = !fifo_full;

    assign {pop_rad, pop_deg, pop_tag} = fifo_rdata;

    root_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Dispatch FSM: pop, classify, run the engine (or not), then present
    // the response until the consumer takes it.
    always_comb begin
        state_d    = state_q;
        fifo_pop   = 1'b0;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (pop_deg == '0) begin
                        state_d = REJECT;
                    end
`ifdef ROOT_DISPATCH_BYPASS_EN
                    else if (bypass_eligible(pop_rad, pop_deg)) begin
                        state_d = BYPASS;
                    end
`endif
                    else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (eng_out_valid) begin
                    rsp_data_d = eng_out_data;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end
            end
            REJECT: begin
                rsp_data_d = '0;
                rsp_err_d  = 1'b1;
                state_d    = RESP;
            end
`ifdef ROOT_DISPATCH_BYPASS_EN
            BYPASS: begin
                rsp_data_d = bypass_result(rad_q, deg_q);
                rsp_err_d  = 1'b0;
                state_d    = RESP;
            end
`endif
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and response payload registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Hold registers: loaded only on a pop, which happens only in IDLE, so
    // the engine operands and response tag are stable for the whole
    // transaction including the RESP back-pressure window.
    always_ff @(posedge clk) begin
        if (rst) begin
            rad_q <= '0;
            deg_q <= '0;
            tag_q <= '0;
        end else if (fifo_pop) begin
            rad_q <= pop_rad;
            deg_q <= pop_deg;
            tag_q <= pop_tag;
        end
    end

    assign eng_in_valid = (state_q == ISSUE);
    assign eng_data_1   = rad_q;
    assign eng_data_2   = deg_q;

    assign rsp_valid    = (state_q == RESP);
    assign rsp_data     = rsp_data_q;
    assign rsp_tag      = tag_q;
    assign rsp_err      = rsp_err_q;

endmodule

// File: doc/root_dispatch.md
# root_dispatch

Request front-end for the fixed-point root engine. Buffers incoming (radicand, degree, tag) requests in a small FIFO, feeds the engine one request at a time while holding its operands stable for the whole computation, and captures the single-cycle result pulse into a ready/valid response port. Engine-side ports connect directly to the engine's `in_valid`/`in_data_1`/`in_data_2`/`out_valid`/`out_data`.

## Interface
- `DEPTH`, 4: request FIFO entries; power of two, ≥2.
- `TAG_W`, 4: width of the request tag carried through to the response.

- `clk` in 1: the single clock.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: FIFO can accept.
- `req_radicand` in 10: unsigned integer radicand.
- `req_degree` in 3: root degree n.
- `req_tag` in TAG_W: opaque tag.
- `eng_in_valid` out 1: one-cycle start pulse to the engine.
- `eng_data_1` out 10: radicand to the engine.
- `eng_data_2` out 3: degree to the engine.
- `eng_out_valid` in 1: engine result pulse.
- `eng_out_data` in 20: engine result, Q10.10.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts.
- `rsp_data` out 20: result, Q10.10 unsigned.
- `rsp_tag` out TAG_W: tag of the originating request.
- `rsp_err` out 1: request rejected (degree 0).

## Operation
- FIFO: push on `req_valid && req_ready`. `req_ready = !full`, from the registered count. No fall-through: a pushed entry becomes poppable the next cycle. Pushes and pops in the same cycle are legal when neither full nor empty. Count wraps never: overflow and underflow are impossible by construction.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop into the hold registers (radicand, degree, tag). Go to REJECT if degree==0, else ISSUE.
  - ISSUE: `eng_in_valid=1` for exactly this cycle. Go to WAIT.
  - WAIT: on `eng_out_valid`, capture `eng_out_data` into `rsp_data`, clear `rsp_err`, go to RESP.
  - REJECT: `rsp_data=0`, `rsp_err=1`, go to RESP. The engine is not touched.
  - RESP: `rsp_valid=1`. On `rsp_ready`, go to IDLE.
- `eng_data_1`/`eng_data_2` are driven from the hold registers. They change only on a pop in IDLE, so they are stable from ISSUE until the cycle after the result pulse.
- `eng_out_valid` is ignored outside WAIT.
- Only one request is in flight at a time. A new issue occurs only after the previous response has been accepted, which also guarantees that the engine has returned to its idle state.
- `rsp_data`, `rsp_tag` and `rsp_err` stay constant while `rsp_valid && !rsp_ready`.

## Timing
- Reset values: `req_ready=1`, `eng_in_valid=0`, `eng_data_1=0`, `eng_data_2=0`, `rsp_valid=0`, `rsp_data=0`, `rsp_tag=0`, `rsp_err=0`. FIFO is empty and FSM is in IDLE.
- Push at cycle t gives earliest pop at t+1 and `eng_in_valid` at t+2.
- `eng_out_valid` at cycle u gives `rsp_valid` at u+1.
- Reject path: pop at p gives `rsp_valid` at p+2.
- Minimum response-to-next-issue gap: `rsp_valid && rsp_ready` at r, pop at r+1, `eng_in_valid` at r+2.
- Reset in any state (including WAIT): the in-flight request and FIFO contents are discarded, and no response is generated for them.

## Configuration
- `ROOT_DISPATCH_BYPASS_EN`
  - Defined: in IDLE, a popped request with degree==1 or radicand==0 (and degree≠0) goes to a BYPASS state. BYPASS loads `rsp_data = {radicand, 10'b0}` for degree 1, or 0 for radicand 0, with `rsp_err=0`, then goes to RESP. The engine is not started.
  - Undefined: these requests go through ISSUE/WAIT like any other. `rsp_data` values are identical; only latency differs.

## Structure
- Shared package `root_pkg` holds:
  - the FSM state enum: IDLE, ISSUE, WAIT, REJECT, BYPASS, RESP;
  - `RADICAND_W=10`, `DEGREE_W=3`, `RESULT_W=20`, `FRAC_W=10`.
- One sub-module, `root_req_fifo`: a synchronous FIFO, parameterised on DEPTH and entry width, with registered count and full/empty flags.

## Test plan
- Radicand 16, degree 2, `rsp_ready=1` → one `eng_in_valid` pulse with `eng_data_1=16`, `eng_data_2=2`; `rsp_data=0x01000`, tag echoed, `rsp_err=0`.
- Degree 0, radicand 5, tag 3 → `rsp_err=1`, `rsp_data=0`, `rsp_tag=3`, 2 cycles after the pop; `eng_in_valid` never asserted.
- Six back-to-back requests with `DEPTH=4` while the engine is busy → `req_ready` drops after the FIFO holds 4 entries. All six responses arrive in order with their tags.
- `rsp_ready` held low for 20 cycles after `rsp_valid` → response fields constant and no new `eng_in_valid`. Issue resumes 2 cycles after `rsp_ready` rises.
- Radicand 7, degree 1 → `rsp_data=0x01C00` in both builds.
  - With `ROOT_DISPATCH_BYPASS_EN`: no `eng_in_valid`, `rsp_valid` 2 cycles after the pop.
  - Without it: the result comes via the engine.
- `rst` asserted in WAIT, then a stray `eng_out_valid` after release → no `rsp_valid`, FIFO empty, all outputs at reset values.
